// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared types and constants for the seven-segment capture path.
//             Glyph table is indexed by hex value; bit0 = segment a ...
//             bit6 = segment g, active low (0 = segment lit).
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'b1111111;

    localparam seg7_t SEG7_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        ST_WATCH  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCEPT = 2'd2
    } seg7_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_lookup.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_glyph_lookup
//  Purpose  : Combinational pattern -> {legal, digit} decode of an active-low
//             seven-segment glyph.
//  Ports    : i_seg   [6:0] segment pattern (bit0 = a ... bit6 = g)
//             o_legal       pattern is a recognised hex glyph
//             o_digit [3:0] decoded value (0 when not legal)
//  Config   : SEG7_ALT_GLYPH_EN adds the alternate 7 (with segment f) and
//             9 (without segment d) glyphs.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_glyph_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic [3:0] o_digit
);

    always_comb begin
        o_legal = 1'b0;
        o_digit = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG7_GLYPH[i]) begin
                o_legal = 1'b1;
                o_digit = 4'(i);
            end
        end
`ifdef SEG7_ALT_GLYPH_EN
        // The "6 without a" variant would alias b, so only 7 and 9 variants.
        if (i_seg == 7'b1011000) begin
            o_legal = 1'b1;
            o_digit = 4'h7;
        end
        if (i_seg == 7'b0011000) begin
            o_legal = 1'b1;
            o_digit = 4'h9;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_capture_decoder
//  Purpose  : Samples an external active-low seven-segment bus, debounces it
//             and decodes stable glyphs back to hex digits, delivered through
//             a one-entry valid/ready output register.
//  Ports    : clk, reset (async, active high)
//             seg_in      [6:0] active-low segments, bit0 = a ... bit6 = g
//             digit       [3:0] decoded value, stable while digit_valid
//             digit_valid / digit_ready   output handshake
//             blank       last accepted pattern was all-off
//             invalid     last accepted pattern was neither glyph nor blank
//             overrun     sticky, a digit was dropped; cleared by overrun_clr
//  Params   : SYNC_STAGES (>=2), STABLE_CYCLES (>=1)
//  Config   : SEG7_ALT_GLYPH_EN (in seg7_glyph_lookup) widens the glyph set.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       blank,
    output logic       invalid,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam int                 c_cnt_w  = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYCLES);

    // The last synchronizer stage doubles as the debounce candidate; the
    // change test looks one stage earlier so the count starts the same edge
    // the candidate changes.
    seg7_t              r_sync [SYNC_STAGES-1];
    seg7_t              r_cand;
    seg7_t              r_last_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    seg7_state_t        r_state;

    logic               w_change;
    logic               w_legal;
    logic [3:0]         w_digit;
    logic               w_is_blank;
    logic               w_emit;

    assign w_change   = (r_sync[SYNC_STAGES-2] != r_cand);
    assign w_is_blank = (r_cand == SEG7_BLANK);
    assign w_emit     = (r_state == ST_ACCEPT) && w_legal && (r_cand != r_last_acc);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_change) begin
            w_cnt_next = '0;
        end else if (r_cnt != c_stable) begin
            w_cnt_next = r_cnt + c_cnt_w'(1);
        end
    end

    seg7_glyph_lookup u_lookup (
        .i_seg   (r_cand),
        .o_legal (w_legal),
        .o_digit (w_digit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES - 1; i++) begin
                r_sync[i] <= SEG7_BLANK;
            end
            r_cand <= SEG7_BLANK;
            r_cnt  <= '0;
        end else begin
            r_sync[0] <= seg_in;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_cand <= r_sync[SYNC_STAGES-2];
            r_cnt  <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_WATCH;
            r_last_acc  <= SEG7_BLANK;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            blank       <= 1'b0;
            invalid     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            case (r_state)
                ST_WATCH: begin
                    if (w_change) begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_cnt_next == c_stable) begin
                        r_state <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    r_last_acc <= r_cand;
                    blank      <= w_is_blank;
                    invalid    <= !w_legal && !w_is_blank;
                    // A change arriving during the accept cycle must not be lost.
                    r_state    <= w_change ? ST_SETTLE : ST_WATCH;
                end
                default: r_state <= ST_WATCH;
            endcase

            // Output register: a transfer in the emit cycle frees the slot.
            if (w_emit && (!digit_valid || digit_ready)) begin
                digit       <= w_digit;
                digit_valid <= 1'b1;
            end else if (digit_valid && digit_ready) begin
                digit_valid <= 1'b0;
            end

            // A fresh drop outranks a simultaneous clear.
            if (w_emit && digit_valid && !digit_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_capture_decoder
//  Purpose  : Self-checking bench for seg7_capture_decoder (SYNC_STAGES=2,
//             STABLE_CYCLES=4) with a run-length behavioural model and
//             directed stimulus. Honours SEG7_ALT_GLYPH_EN for the alternate 7.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_capture_decoder;

    localparam int SYNC = 2;
    localparam int STAB = 4;
    localparam logic [6:0] BLK = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_ready;
    logic       blank;
    logic       invalid;
    logic       overrun;
    logic       overrun_clr;

    int tests = 0;
    int fails = 0;

    seg7_capture_decoder #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .blank       (blank),
        .invalid     (invalid),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Glyph table straight from the segment drawings.
    function automatic bit glyph(input logic [6:0] p, output logic [3:0] d);
        bit ok;
        ok = 1'b1;
        case (p)
            7'b1000000: d = 4'h0;  7'b1111001: d = 4'h1;
            7'b0100100: d = 4'h2;  7'b0110000: d = 4'h3;
            7'b0011001: d = 4'h4;  7'b0010010: d = 4'h5;
            7'b0000010: d = 4'h6;  7'b1111000: d = 4'h7;
            7'b0000000: d = 4'h8;  7'b0010000: d = 4'h9;
            7'b0001000: d = 4'hA;  7'b0000011: d = 4'hB;
            7'b1000110: d = 4'hC;  7'b0100001: d = 4'hD;
            7'b0000110: d = 4'hE;  7'b0001110: d = 4'hF;
`ifdef SEG7_ALT_GLYPH_EN
            7'b1011000: d = 4'h7;  7'b0011000: d = 4'h9;
`endif
            default: begin d = 4'h0; ok = 1'b0; end
        endcase
        return ok;
    endfunction

    // Model: the candidate seen after edge k is seg_in delayed SYNC-1 edges;
    // a pattern is taken one edge after its candidate run reaches STAB+1.
    logic [6:0] m_pipe [$];
    logic [6:0] m_cand, m_last;
    int         m_run;
    logic [3:0] m_digit;
    logic       m_valid, m_blank, m_invalid, m_ovr;

    always @(posedge clk or posedge reset) begin
        bit         leg, emit, drop;
        logic [3:0] d;
        logic [6:0] nc;
        if (reset) begin
            m_pipe = {};
            for (int i = 0; i < SYNC - 1; i++) m_pipe.push_back(BLK);
            m_cand = BLK; m_last = BLK; m_run = 1000;
            m_digit = 4'h0; m_valid = 1'b0; m_blank = 1'b0;
            m_invalid = 1'b0; m_ovr = 1'b0;
        end else begin
            emit = 1'b0;
            drop = 1'b0;
            d    = 4'h0;
            if (m_run == STAB + 1) begin
                leg       = glyph(m_cand, d);
                emit      = leg && (m_cand != m_last);
                m_blank   = (m_cand == BLK);
                m_invalid = !leg && !m_blank;
                m_last    = m_cand;
            end
            if (emit) begin
                if (!m_valid || digit_ready) begin
                    m_digit = d;
                    m_valid = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (m_valid && digit_ready) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
            m_pipe.push_back(seg_in);
            nc = m_pipe.pop_front();
            if (nc == m_cand) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_cand = nc;
        end
    end

    logic [3:0] xfers [$];

    always @(negedge clk) begin
        chk("cyc_digit",   digit,       m_digit);
        chk("cyc_valid",   digit_valid, m_valid);
        chk("cyc_blank",   blank,       m_blank);
        chk("cyc_invalid", invalid,     m_invalid);
        chk("cyc_overrun", overrun,     m_ovr);
        if (digit_valid && digit_ready) xfers.push_back(digit);
    end

    function automatic logic [31:0] xf(input int i);
        return (xfers.size() > i) ? 32'(xfers[i]) : 32'hDEAD;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        cyc(n);
    endtask

    initial begin
        reset = 1'b0; seg_in = BLK; digit_ready = 1'b1; overrun_clr = 1'b0;
        #1 reset = 1'b1;
        cyc(2);
        chk("rst_digit", digit, 0);  chk("rst_valid", digit_valid, 0);
        chk("rst_blank", blank, 0);  chk("rst_invalid", invalid, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        cyc(3);

        // Latency: valid exactly at edge 7, single-cycle pulse with ready=1.
        seg_in = 7'b0100100;
        cyc(6); chk("lat_early", digit_valid, 0);
        cyc(1); chk("lat_valid", digit_valid, 1); chk("lat_digit", digit, 2);
        chk("lat_blank", blank, 0); chk("lat_invalid", invalid, 0);
        cyc(1); chk("lat_pulse", digit_valid, 0);
        cyc(4);

        // Short glitch and return to the accepted pattern: no emission.
        hold(7'b0110000, 12);
        xfers.delete();
        hold(7'b1111001, 3);
        hold(7'b0110000, 12);
        hold(7'b0001110, 12);
        chk("glitch_count", xfers.size(), 1); chk("glitch_F", xf(0), 4'hF);

        // Repeat of a digit only after an intervening blank.
        xfers.delete();
        hold(7'b0010010, 12);
        hold(BLK, 8);
        chk("blank_lvl", blank, 1); chk("blank_inv", invalid, 0);
        hold(7'b0010010, 12);
        hold(BLK, 2);
        hold(7'b0010010, 12);
        chk("rep_count", xfers.size(), 2);
        chk("rep_d0", xf(0), 5); chk("rep_d1", xf(1), 5);

        // Full output register, overrun and its clear.
        digit_ready = 1'b0;
        hold(7'b1111001, 12);
        hold(7'b0000000, 12);
        chk("ovr_digit", digit, 1); chk("ovr_valid", digit_valid, 1);
        chk("ovr_set", overrun, 1);
        overrun_clr = 1'b1; cyc(1); overrun_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        seg_in = 7'b0000011;
        cyc(6); digit_ready = 1'b1;
        cyc(1); digit_ready = 1'b0;
        chk("xfer_emit_digit", digit, 4'hB); chk("xfer_emit_valid", digit_valid, 1);
        chk("xfer_emit_ovr", overrun, 0);
        seg_in = 7'b0000110;
        cyc(6); overrun_clr = 1'b1;
        cyc(1); overrun_clr = 1'b0;
        chk("set_wins", overrun, 1); chk("set_wins_digit", digit, 4'hB);
        overrun_clr = 1'b1; cyc(1); overrun_clr = 1'b0;
        digit_ready = 1'b1;
        cyc(3);

        // Alternate 7 glyph.
        xfers.delete();
        hold(7'b1011000, 12);
`ifdef SEG7_ALT_GLYPH_EN
        chk("alt7_count", xfers.size(), 1); chk("alt7_digit", xf(0), 7);
        chk("alt7_invalid", invalid, 0);
`else
        chk("alt7_count", xfers.size(), 0); chk("alt7_invalid", invalid, 1);
        chk("alt7_blank", blank, 0);
`endif

        // Reset with a pending digit and during settling.
        digit_ready = 1'b0;
        hold(7'b1111001, 12);
        chk("pend_valid", digit_valid, 1);
        seg_in = 7'b0000010;
        cyc(3);
        #1 reset = 1'b1;
        #1;
        chk("arst_digit", digit, 0); chk("arst_valid", digit_valid, 0);
        chk("arst_blank", blank, 0); chk("arst_invalid", invalid, 0);
        chk("arst_overrun", overrun, 0);
        seg_in = BLK;
        cyc(2);
        reset = 1'b0;
        xfers.delete();
        digit_ready = 1'b1;
        cyc(20);
        chk("post_rst_count", xfers.size(), 0);
        chk("post_rst_valid", digit_valid, 0);
        chk("post_rst_blank", blank, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Inverse of the team's nibble-to-seven-segment driver: samples an external active-low 7-segment bus, debounces it and decodes stable glyphs back to 4-bit hex digits.
- Used in the DE2-115 PS/2 and LCD demos to read digits driven by another board or a legacy display into logic.
- Delivers each new digit through a one-entry valid/ready output register.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on seg_in (minimum 2).
- STABLE_CYCLES, 16, consecutive equal synchronized samples required to accept a pattern (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- seg_in  in  7  active-low segments; bit0=a … bit6=g.
- digit  out  4  decoded hex value.
- digit_valid  out  1  digit holds an undelivered value.
- digit_ready  in  1  consumer accepts digit.
- blank  out  1  level; last accepted pattern was all-off (7'b1111111).
- invalid  out  1  level; last accepted pattern is not a legal glyph and not blank.
- overrun  out  1  sticky; a digit was dropped because the output register was full.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset: all outputs 0; synchronizer and candidate registers load 7'b1111111; counter 0; last_acc = blank.
- Glyph table, pattern→digit:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
- Debounce: candidate = synchronized sample.
  - Counter clears to 0 on any change.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
  - The pattern is accepted in the cycle the counter reaches STABLE_CYCLES.
  - A glitch shorter than STABLE_CYCLES produces no effect.
- FSM (WATCH, SETTLE, ACCEPT):
  - WATCH: candidate equals last_acc. A change moves to SETTLE.
  - SETTLE: counting. A change restarts the count; reaching STABLE_CYCLES moves to ACCEPT.
  - ACCEPT: one cycle. Update last_acc, blank and invalid, then return to WATCH.
- On acceptance:
  - Legal glyph different from last_acc: emit the digit. Clear blank and invalid.
  - Blank: blank=1, invalid=0, no emission.
  - Illegal pattern: invalid=1, blank=0, no emission.
  - A legal glyph equal to last_acc is never re-emitted. A repeated digit is emitted again only after an intervening blank, illegal or different glyph.
- Latency: a clean seg_in change reaches the output with digit_valid=1 at edge SYNC_STAGES+STABLE_CYCLES+1 after the first sampling edge. With defaults this is 19.
- Handshake:
  - Transfer occurs when digit_valid && digit_ready.
  - digit is stable while digit_valid=1.
  - After a transfer with no new emit, digit_valid falls on the next edge.
- Output register full:
  - Emit while digit_valid=1 and digit_ready=0: keep the old digit, drop the new one, set overrun.
  - Emit in the same cycle as a transfer: load the new digit, digit_valid stays 1, no overrun.
- overrun: held until overrun_clr or reset. If overrun_clr coincides with a new drop, the set wins.
- digit_ready while digit_valid=0 is ignored.
- reset mid-settle or with a pending digit: the pending digit is discarded, no residual emission; the flags clear.

Optional Feature:
- Macro: SEG7_ALT_GLYPH_EN.
- When defined, these variants are also accepted as legal:
  - 6 without segment a: 0000011 still decodes as b, so the variant is 0000011? No — the variant is 0000010 with a off, i.e. 0000011; because this aliases b, the 6 variant is excluded.
  - 7 with segment f: 1011000→7.
  - 9 with segment d off: 0011000→9.
  - Result: exactly two extra entries, 1011000 and 0011000.
- When undefined, both patterns are illegal and set invalid.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg7_t (7-bit pattern).
  - constants SEG7_BLANK = 7'b1111111 and SEG7_GLYPH[16].
  - FSM state enum.
- Sub-module seg7_glyph_lookup: combinational pattern→{legal, digit}, containing the SEG7_ALT_GLYPH_EN table. It is shared later with the encoder for self-checking.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4):
- seg_in=0100100 held, digit_ready=1 → digit_valid at edge 7 with digit=2, one-cycle pulse, blank=invalid=0.
- 1111001 for 3 cycles then back to the prior 0110000 → no emission; a subsequent 0001110 held → digit=F.
- 0010010 held, blank 1111111 held, 0010010 held → digit 5 emitted twice; blank=1 between; no emission for the identical pattern without the blank.
- digit_ready=0; emit 1 then 0000000 → digit stays 1, overrun=1. overrun_clr pulse → 0. Emit coinciding with a transfer → new digit loads, overrun stays 0.
- 1011000 held → invalid=1 without the macro; digit=7 with SEG7_ALT_GLYPH_EN.
- Assert reset during SETTLE and with digit_valid=1 → all outputs 0 asynchronously; after release with seg_in=blank → no emission.
